// File: rtl/line_buffer_frame_sequencer_if.sv
// Frame memory read port: the sequencer drives the read strobe and
// address, the synchronous-read memory returns data one cycle later.
interface line_buffer_frame_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  memRdEn;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memRdData;

    modport master (
        output memRdEn,
        output memAddr,
        input  memRdData
    );

    modport slave (
        input  memRdEn,
        input  memAddr,
        output memRdData
    );
endinterface

// File: rtl/line_buffer_frame_sequencer.sv
// Streams one frame from the frame memory into the line buffer in raster
// order, counts the kernel windows coming back, and reports completion
// once the line buffer has gone quiet for DRAIN_IDLE_CYCLES cycles.
module line_buffer_frame_sequencer #(
    parameter int FIXED_POINT_SIZE  = 16,
    parameter int IMAGE_WIDTH       = 32,
    parameter int IMAGE_HEIGHT      = 32,
    parameter int ADDR_WIDTH        = 16,
    parameter int WIN_CNT_WIDTH     = 12,
    parameter int DRAIN_IDLE_CYCLES = 64
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 start,
    input  logic [ADDR_WIDTH-1:0]                frameBase,
    input  logic                                 pauseIn,
    output logic                                 busy,
    output logic                                 done,
    line_buffer_frame_sequencer_if.master        mem_bus,
    output logic [FIXED_POINT_SIZE-1:0]          dataOut,
    output logic                                 dataValidOut,
    input  logic                                 windowValidIn,
    output logic [WIN_CNT_WIDTH-1:0]             windowCount
);

    localparam int PIXEL_COUNT = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int IDX_WIDTH   = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
    localparam int IDLE_WIDTH  = $clog2(DRAIN_IDLE_CYCLES + 1);

    localparam logic [IDX_WIDTH-1:0]     LAST_INDEX  = IDX_WIDTH'(PIXEL_COUNT - 1);
    // The done cycle itself is the last window-free cycle, so the counter
    // only has to see DRAIN_IDLE_CYCLES-1 quiet cycles before leaving DRAIN.
    localparam logic [IDLE_WIDTH-1:0]    IDLE_LIMIT  = IDLE_WIDTH'(DRAIN_IDLE_CYCLES - 2);
    localparam logic [WIN_CNT_WIDTH-1:0] WIN_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    read_en;
    logic                    start_accept;
    logic                    valid_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [IDX_WIDTH-1:0]    pixel_idx;
    logic [IDLE_WIDTH-1:0]   idle_cnt;

    assign busy             = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    assign done             = (state_q == ST_DONE);
    assign mem_bus.memRdEn  = read_en;
    assign mem_bus.memAddr  = base_q + ADDR_WIDTH'(pixel_idx);
    assign dataValidOut     = valid_q;
    // The memory already registers its read data, so gating it with the
    // delayed strobe keeps pixel and valid aligned one cycle after the read.
    assign dataOut          = valid_q ? mem_bus.memRdData : '0;

    // Next-state decode and read strobe generation.
    always_comb begin
        state_d      = state_q;
        read_en      = 1'b0;
        start_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = ST_FEED;
                end
            end
            ST_FEED: begin
                if (!pauseIn) begin
                    read_en = 1'b1;
                    if (pixel_idx == LAST_INDEX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!windowValidIn && (idle_cnt == IDLE_LIMIT)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame in flight without a done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched base, raster pixel index and the drain quiet-cycle counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_q    <= '0;
            pixel_idx <= '0;
            idle_cnt  <= '0;
        end else begin
            if (start_accept) begin
                base_q    <= frameBase;
                pixel_idx <= '0;
            end else if (read_en) begin
                pixel_idx <= pixel_idx + IDX_WIDTH'(1);
            end

            if (state_q == ST_DRAIN) begin
                idle_cnt <= windowValidIn ? '0 : idle_cnt + IDLE_WIDTH'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    // One-cycle delay of the read strobe becomes the line buffer's valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= read_en;
        end
    end

    // Saturating window counter, cleared only by an accepted start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            windowCount <= '0;
        end else if (start_accept) begin
            windowCount <= '0;
        end else if (windowValidIn && busy && (windowCount != WIN_CNT_MAX)) begin
            windowCount <= windowCount + WIN_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_line_buffer_frame_sequencer.sv
// Directed bench for the frame sequencer: a synchronous-read memory model,
// a line buffer stand-in that returns one window per pixel at row>=4 and
// col>=4 (28x28 = 784 windows), and a read/data scoreboard queue.
module tb_line_buffer_frame_sequencer;

    localparam int FP   = 16;
    localparam int IW   = 32;
    localparam int IH   = 32;
    localparam int AW   = 16;
    localparam int WCW  = 12;
    localparam int DIC  = 64;
    localparam int NPIX = IW * IH;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic           pauseIn = 1'b0;
    logic           windowValidIn = 1'b0;
    logic [AW-1:0]  frameBase = '0;
    logic           busy;
    logic           done;
    logic           dataValidOut;
    logic [FP-1:0]  dataOut;
    logic [WCW-1:0] windowCount;

    line_buffer_frame_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(FP)) mem_bus ();

    line_buffer_frame_sequencer #(
        .FIXED_POINT_SIZE (FP),
        .IMAGE_WIDTH      (IW),
        .IMAGE_HEIGHT     (IH),
        .ADDR_WIDTH       (AW),
        .WIN_CNT_WIDTH    (WCW),
        .DRAIN_IDLE_CYCLES(DIC)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .frameBase    (frameBase),
        .pauseIn      (pauseIn),
        .busy         (busy),
        .done         (done),
        .mem_bus      (mem_bus),
        .dataOut      (dataOut),
        .dataValidOut (dataValidOut),
        .windowValidIn(windowValidIn),
        .windowCount  (windowCount)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Frame memory contents: a byte swap plus xor, distinct per address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Synchronous-read frame memory model.
    always @(posedge clk) begin
        if (mem_bus.memRdEn) mem_bus.memRdData <= mem_word(mem_bus.memAddr);
    end

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rd_cnt, out_cnt, win_pending, done_cnt;
    int          done_cyc, last_win_cyc, first_busy_cyc, last_rd_cyc, first_wc;
    logic        busy_at_done, busy_before_done, prev_busy, last_busy;
    logic        win_en = 1'b1;
    logic        force_win = 1'b0;
    logic [15:0] exp_addr, last_rd_addr;
    logic [15:0] exp_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Samples DUT outputs mid-cycle and runs the scoreboard.
    task automatic observe();
        if (dataValidOut) begin
            if (exp_q.size() == 0) checkOutput("valid_without_read", exp_q.size(), 1);
            else checkOutput("data_out", dataOut, exp_q.pop_front());
            if ((out_cnt / IW) >= 4 && (out_cnt % IW) >= 4) win_pending++;
            out_cnt++;
        end else begin
            checkOutput("data_out_idle", dataOut, 0);
        end
        if (mem_bus.memRdEn) begin
            checkOutput("rd_addr", mem_bus.memAddr, exp_addr);
            exp_q.push_back(mem_word(exp_addr));
            last_rd_addr = exp_addr;
            exp_addr     = exp_addr + 16'd1;
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        if (windowValidIn) last_win_cyc = cyc;
        if (busy && first_busy_cyc < 0) begin
            first_busy_cyc = cyc;
            first_wc       = windowCount;
        end
        if (done) begin
            done_cnt++;
            done_cyc         = cyc;
            busy_at_done     = busy;
            busy_before_done = prev_busy;
        end
        prev_busy = busy;
        last_busy = busy;
    endtask

    // One clock: observe at the falling edge, then drive the window model.
    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
        if (win_en && win_pending > 0) begin
            windowValidIn = 1'b1;
            win_pending--;
        end else begin
            windowValidIn = force_win;
        end
    endtask

    // Runs one frame; optional stray starts and a mid-frame reset abort.
    task automatic applyStimulus(input logic [15:0] base, input bit pause_mode,
                                 input int feed_start_at, input bit start_at_done,
                                 input int abort_at_read);
        exp_q.delete();
        exp_addr = base; rd_cnt = 0; out_cnt = 0; win_pending = 0; done_cnt = 0;
        done_cyc = -1; last_win_cyc = -1; first_busy_cyc = -1; last_rd_cyc = -1; first_wc = -1;
        frameBase = base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        frameBase = 16'h7777;
        for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
            pauseIn = pause_mode && (i % 3 == 0);
            start   = (i == feed_start_at) || (start_at_done && done);
            if (abort_at_read > 0 && rd_cnt == abort_at_read) begin
                #2 resetn = 1'b0;
                #1;
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_done", done, 0);
                checkOutput("abort_rden", mem_bus.memRdEn, 0);
                checkOutput("abort_addr", mem_bus.memAddr, 0);
                checkOutput("abort_valid", dataValidOut, 0);
                checkOutput("abort_data", dataOut, 0);
                checkOutput("abort_wc", windowCount, 0);
                win_pending = 0;
                start = 1'b0;
                pauseIn = 1'b0;
                tick();
                tick();
                resetn = 1'b1;
                tick();
                checkOutput("abort_no_done", done_cnt, 0);
                checkOutput("abort_reads", rd_cnt, abort_at_read);
                checkOutput("abort_idle", last_busy, 0);
                return;
            end
            tick();
        end
        pauseIn = 1'b0;
        start   = 1'b0;
        if (done_cnt == 0) checkOutput("frame_timeout", done_cnt, 1);
    endtask

    // End-of-frame checks; the tail cycle confirms done width and IDLE.
    task automatic postFrameChecks(input int exp_feed_len, input bit tail);
        checkOutput("reads", rd_cnt, NPIX);
        checkOutput("outputs", out_cnt, NPIX);
        checkOutput("queue_left", exp_q.size(), 0);
        checkOutput("feed_len", last_rd_cyc - first_busy_cyc + 1, exp_feed_len);
        checkOutput("wc_start", first_wc, 0);
        checkOutput("win_count", windowCount, 784);
        checkOutput("done_gap", done_cyc - last_win_cyc, DIC);
        checkOutput("busy_at_done", busy_at_done, 0);
        checkOutput("busy_before_done", busy_before_done, 1);
        if (tail) begin
            tick();
            checkOutput("done_width", done_cnt, 1);
            checkOutput("idle_after_done", last_busy, 0);
            checkOutput("wc_hold", windowCount, 784);
        end
    endtask

    initial begin
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rden", mem_bus.memRdEn, 0);
        checkOutput("rst_addr", mem_bus.memAddr, 0);
        checkOutput("rst_valid", dataValidOut, 0);
        checkOutput("rst_wc", windowCount, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        $display("[TB] frame at 0x0100, no pauses");
        applyStimulus(16'h0100, 1'b0, -1, 1'b0, 0);
        postFrameChecks(NPIX, 1'b1);

        $display("[TB] window pulse in IDLE is ignored");
        force_win = 1'b1;
        tick();
        force_win = 1'b0;
        tick();
        tick();
        checkOutput("wc_idle_ignored", windowCount, 784);

        $display("[TB] frame with pause on every third FEED cycle");
        applyStimulus(16'h0100, 1'b1, -1, 1'b0, 0);
        postFrameChecks(1536, 1'b1);

        $display("[TB] address wrap from 0xFF00");
        applyStimulus(16'hFF00, 1'b0, -1, 1'b0, 0);
        postFrameChecks(NPIX, 1'b1);
        checkOutput("wrap_last_addr", last_rd_addr, 16'h02FF);

        $display("[TB] stray starts in FEED and DONE, then back-to-back frame");
        applyStimulus(16'h0200, 1'b0, 100, 1'b1, 0);
        postFrameChecks(NPIX, 1'b0);
        applyStimulus(16'h0300, 1'b0, -1, 1'b0, 0);
        postFrameChecks(NPIX, 1'b1);

        $display("[TB] reset at read 500, then a clean frame");
        applyStimulus(16'h0100, 1'b0, -1, 1'b0, 500);
        applyStimulus(16'h0100, 1'b0, -1, 1'b0, 0);
        postFrameChecks(NPIX, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
